// File: rtl/counter_status_tx.sv
// counter_status_tx: pushes an ASCII status line ("R/S", "U/D", "C/-", LF) into the UART TX FIFO
// whenever the counter control levels change. Define STATUS_CRLF_EN to end lines with CR LF.
module counter_status_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic       i_mode,
  input  logic       i_clear,
  input  logic       i_tx_full,
  output logic       o_push,
  output logic [7:0] o_push_data,
  output logic       o_busy
);

`ifdef STATUS_CRLF_EN
  localparam int MSG_LEN = 5;
`else
  localparam int MSG_LEN = 4;
`endif

  // FIFO handshake: a byte is written on the rising edge where o_push = 1; o_push is only
  // raised in SEND while i_tx_full = 0, and o_push_data holds the current byte until written.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e     state_q;
  logic       run_q;
  logic       mode_q;
  logic       clr_seen_q;
  logic       pend_q;
  logic       snap_run_q;
  logic       snap_mode_q;
  logic       snap_clr_q;
  logic [2:0] idx_q;

  logic       evt;
  logic       push;
  logic       last_byte;
  logic       take_snap;
  logic [7:0] byte_d;

  assign evt       = (i_run != run_q) | (i_mode != mode_q) | i_clear;
  assign push      = (state_q == SEND) & ~i_tx_full;
  assign last_byte = (idx_q == 3'(MSG_LEN - 1));
  // An event on the final push edge restarts directly rather than parking in pend.
  assign take_snap = ((state_q == IDLE) & evt) | (push & last_byte & (pend_q | evt));

  always_comb begin
    byte_d = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        3'd0:    byte_d = snap_run_q  ? 8'h52 : 8'h53;
        3'd1:    byte_d = snap_mode_q ? 8'h44 : 8'h55;
        3'd2:    byte_d = snap_clr_q  ? 8'h43 : 8'h2D;
`ifdef STATUS_CRLF_EN
        3'd3:    byte_d = 8'h0D;
        3'd4:    byte_d = 8'h0A;
`else
        3'd3:    byte_d = 8'h0A;
`endif
        default: byte_d = 8'h00;
      endcase
    end
  end

  assign o_push      = push;
  assign o_push_data = byte_d;
  assign o_busy      = (state_q == SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      mode_q      <= 1'b0;
      clr_seen_q  <= 1'b0;
      pend_q      <= 1'b0;
      snap_run_q  <= 1'b0;
      snap_mode_q <= 1'b0;
      snap_clr_q  <= 1'b0;
      idx_q       <= 3'd0;
    end else begin
      run_q  <= i_run;
      mode_q <= i_mode;
      if (take_snap) begin
        state_q     <= SEND;
        snap_run_q  <= i_run;
        snap_mode_q <= i_mode;
        snap_clr_q  <= clr_seen_q | i_clear;
        clr_seen_q  <= 1'b0;
        pend_q      <= 1'b0;
        idx_q       <= 3'd0;
      end else if (state_q == SEND) begin
        if (push && last_byte) begin
          state_q <= IDLE;
          idx_q   <= 3'd0;
        end else begin
          if (push) idx_q <= idx_q + 3'd1;
          if (evt) pend_q <= 1'b1;
          if (i_clear) clr_seen_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_status_tx.sv
// Bench for counter_status_tx: directed scenarios plus random level/full traffic, checked
// against a line-level reference model through an expected-byte queue.
module tb_counter_status_tx;

`ifdef STATUS_CRLF_EN
  localparam int MSG_LEN = 5;
`else
  localparam int MSG_LEN = 4;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       run   = 1'b0;
  logic       mode  = 1'b0;
  logic       clear = 1'b0;
  logic       full  = 1'b0;
  logic       push;
  logic [7:0] push_data;
  logic       busy;

  int n_tests    = 0;
  int n_fail     = 0;
  int lines_seen = 0;
  int base_lines = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  // Reference model: whole lines are queued at the edge they are snapshotted.
  logic m_busy      = 1'b0;
  logic m_prev_run  = 1'b0;
  logic m_prev_mode = 1'b0;
  logic m_clr       = 1'b0;
  logic m_pend      = 1'b0;
  logic m_evt       = 1'b0;
  int   m_left      = 0;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  counter_status_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (run),
    .i_mode     (mode),
    .i_clear    (clear),
    .i_tx_full  (full),
    .o_push     (push),
    .o_push_data(push_data),
    .o_busy     (busy)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%02h expected=%02h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic model_snap();
    exp_q.push_back(run  ? 8'h52 : 8'h53);
    exp_q.push_back(mode ? 8'h44 : 8'h55);
    exp_q.push_back(m_clr ? 8'h43 : 8'h2D);
    if (MSG_LEN == 5) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    m_clr  = 1'b0;
    m_pend = 1'b0;
    m_left = MSG_LEN;
    m_busy = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_prev_run = 1'b0; m_prev_mode = 1'b0;
      m_clr = 1'b0; m_pend = 1'b0; m_left = 0;
      exp_q.delete();
    end else begin
      m_evt = (run != m_prev_run) || (mode != m_prev_mode) || clear;
      if (clear) m_clr = 1'b1;
      if (!m_busy) begin
        if (m_evt) model_snap();
      end else if (!full && m_left == 1) begin
        if (m_pend || m_evt) model_snap();
        else m_busy = 1'b0;
      end else begin
        if (!full) m_left--;
        if (m_evt) m_pend = 1'b1;
      end
      m_prev_run  = run;
      m_prev_mode = mode;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", {7'd0, busy}, {7'd0, m_busy});
      check("push", {7'd0, push}, {7'd0, m_busy && !full});
      if (push) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_push got=%02h expected=none at %0t", push_data, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("data", push_data, exp_b);
          if (push_data == 8'h0A) lines_seen++;
        end
      end else if (!m_busy) begin
        check("idle_data", push_data, 8'h00);
      end
    end
  end

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while ((busy || exp_q.size() != 0) && n < 200);
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout got=busy expected=idle");
    end
    repeat (2) @(posedge clk);
  endtask

  // Stimulus
  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_push", {7'd0, push}, 8'h00);
    check("rst_data", push_data, 8'h00);

    repeat (20) @(posedge clk);

    @(posedge clk); #2 run = 1'b1;
    drain();

    @(posedge clk); #2 mode = 1'b1;
    repeat (2) @(posedge clk); #2 full = 1'b1;
    repeat (5) @(posedge clk); #2 full = 1'b0;
    drain();

    @(posedge clk); #2 run = 1'b0; mode = 1'b0;
    drain();
    base_lines = lines_seen;
    @(posedge clk); #2 clear = 1'b1;
    @(posedge clk); #2 clear = 1'b0; run = 1'b1;
    @(posedge clk); #2 run = 1'b0;
    @(posedge clk); #2 mode = 1'b1;
    drain();
    check_int("coalesce_lines", lines_seen - base_lines, 2);

    @(posedge clk); #2 run = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0; run = 1'b0; mode = 1'b0;
    #1;
    check("abort_busy", {7'd0, busy}, 8'h00);
    check("abort_push", {7'd0, push}, 8'h00);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    base_lines = lines_seen;
    repeat (10) @(posedge clk);
    check_int("post_reset_quiet", lines_seen - base_lines, 0);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(7) == 0) run = ~run;
      if ($urandom_range(7) == 0) mode = ~mode;
      clear = ($urandom_range(9) == 0);
      full  = ($urandom_range(2) == 0);
    end
    clear = 1'b0;
    full  = 1'b0;
    drain();
    check_int("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_status_tx.md
# counter_status_tx

Reports the stop-watch counter's control state back over UART. It watches the three control levels driven by the counter control unit (run, mode, clear). On any change it pushes a fixed-format ASCII status line into the UART TX FIFO, using a push/full handshake. It is the return path of the UART command → counter control chain.

## Interface
Parameters:
- `MSG_LEN`, default 4: bytes per status line. Becomes 5 when `STATUS_CRLF_EN` is defined; not user-overridden.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_run` in 1: counter enable level from the control unit.
- `i_mode` in 1: counter mode level; 0 = up, 1 = down.
- `i_clear` in 1: clear pulse from the control unit, one or more cycles high.
- `i_tx_full` in 1: TX FIFO full flag.
- `o_push` out 1: FIFO write strobe. The FIFO samples it on the rising edge.
- `o_push_data` out 8: byte written when `o_push` = 1.
- `o_busy` out 1: high whenever the state is not IDLE.

## Operation
- Edge-detect registers `run_q` and `mode_q` sample `i_run` and `i_mode` every cycle.
- Event conditions (combinational):
  - `i_run != run_q`, or
  - `i_mode != mode_q`, or
  - `i_clear` = 1.
- Event latching:
  - Any event seen in SEND sets `pend`.
  - `i_clear` = 1 in any state sets `clr_seen`.
- FSM states: IDLE and SEND.
  - IDLE → SEND on the edge where an event condition is true. At that edge, snapshot `run` = `i_run`, `mode` = `i_mode`, `clr` = `clr_seen | i_clear`. Then clear `clr_seen` and `pend`, and set the byte index to 0.
  - In SEND, `o_push = !i_tx_full`. The byte index increments on every edge where `o_push` = 1.
  - On the edge that pushes the last byte:
    - If `pend` = 1 or an event is true, take a fresh snapshot and restart at index 0 (SEND → SEND, no IDLE gap).
    - Otherwise go to IDLE.
- Message bytes, in order:
  - Byte 0: `run` ? 0x52 'R' : 0x53 'S'.
  - Byte 1: `mode` ? 0x44 'D' : 0x55 'U'.
  - Byte 2: `clr` ? 0x43 'C' : 0x2D '-'.
  - Last byte: 0x0A.
- Multiple events during one message coalesce into exactly one follow-up message. The follow-up reports the levels at its own snapshot edge.
- A clear pulse is never lost: it is reported in the current snapshot or the next one.
- The snapshot is frozen for the whole message. Input changes never alter bytes already in flight.

## Timing
- Reset values:
  - `o_push` = 0, `o_push_data` = 0x00, `o_busy` = 0.
  - State = IDLE; `run_q`, `mode_q`, `clr_seen`, `pend` = 0.
  - These match the control unit's reset levels, so no message is sent on reset release.
- Latency: input toggles before edge k → snapshot at edge k → `o_push` = 1 with byte 0 during cycle k+1 (if not full).
- Throughput: one byte per cycle while `i_tx_full` = 0. A 4-byte message occupies 4 cycles minimum.
- Full handling:
  - While `i_tx_full` = 1, `o_push` = 0 and `o_push_data` holds the current byte.
  - No byte is skipped or duplicated.
- `o_push_data` is valid whenever state = SEND. It is 0x00 in IDLE.
- `rst_n` asserted mid-message aborts immediately: outputs return to reset values asynchronously, and the partial line is not resumed.
- An event on the same edge as the last push is taken as a restart, not as `pend`.

## Configuration
- `STATUS_CRLF_EN` defined: lines are 5 bytes, with 0x0D inserted before 0x0A. `MSG_LEN` = 5.
- Not defined: lines are 4 bytes ending in 0x0A only. `MSG_LEN` = 4.

## Test plan
- Reset, hold all inputs 0 for 20 cycles → `o_push` never asserted, `o_busy` = 0.
- `i_run` 0→1, `i_tx_full` = 0 → pushes 0x52 0x55 0x2D 0x0A on 4 consecutive cycles starting one cycle after the sampling edge. Then `o_busy` = 0.
- `i_mode` 0→1 with `i_run` = 1, `i_tx_full` held high 5 cycles mid-message → bytes 0x52 0x44 0x2D 0x0A in order. No push while full, no duplicates.
- `i_clear` 1-cycle pulse, then `i_run` toggles twice and `i_mode` once during that message → exactly two lines: "S U C \n" (first), then one coalesced line with the final levels and '-'.
- Start a message, assert `rst_n` = 0 after byte 1 → `o_push`/`o_busy` drop immediately. After release, no output until a new event.
- With `STATUS_CRLF_EN`: `i_run` 0→1 → 0x52 0x55 0x2D 0x0D 0x0A.
